// File: rtl/segment_led_scan.sv
// segment_led_scan
// Time-multiplexed driver for a common-cathode seven-segment display.
// A latched value is shown either as hex nibbles or as decimal digits
// produced by a sequential double-dabble engine (one shift-and-add-3 step
// per clock). One digit is enabled at a time and each stays selected for
// SCAN_DIV clocks. The display register only changes atomically, so a
// decimal conversion in flight never shows a partial result.
module segment_led_scan #(
  parameter int DIGITS     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_vld_i,
  input  logic                  hex_mode_i,
  input  logic                  lz_blank_i,
  input  logic [DIGITS-1:0]     dp_i,
  output logic                  busy_o,
  output logic                  overflow_o,
  output logic [7:0]            seg_o,
  output logic [DIGITS-1:0]     dig_sel_o
);

  // 10**n as a 64-bit constant; large enough for DIGITS up to 8.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  // Segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      4'hF:    s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  localparam int BCD_W  = 4 * DIGITS;
  localparam int EXT_W  = (DATA_WIDTH > BCD_W) ? DATA_WIDTH : BCD_W;
  localparam int CNT_W  = $clog2(SCAN_DIV);
  localparam int IDX_W  = $clog2(DIGITS);
  localparam int ITER_W = $clog2(DATA_WIDTH);
  localparam logic [63:0] DEC_LIMIT = pow10(DIGITS);

  // Add-3 correction applied to every BCD nibble that is 5 or more, so the
  // following left shift carries correctly into the next decade.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = v[4*k +: 4] + 4'd3;
      end else begin
        r[4*k +: 4] = v[4*k +: 4];
      end
    end
    return r;
  endfunction

  // Conversion / display state
  logic                  busy_q, busy_d;
  logic                  ovf_q, ovf_d;
  logic                  pend_ovf_q, pend_ovf_d;
  logic [DIGITS-1:0]     dp_q, dp_d;
  logic [BCD_W-1:0]      disp_q, disp_d;
  logic [DATA_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic [ITER_W-1:0]     iter_q, iter_d;

  // Scan state and registered pins
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     sel_q, sel_d;

  // Helpers
  logic                  accept_s;
  logic [EXT_W-1:0]      data_ext_s;
  logic                  hex_ovf_s;
  logic                  dec_ovf_s;
  logic [BCD_W-1:0]      bcd_adj_s;
  logic [BCD_W-1:0]      bcd_step_s;
  logic [3:0]            nib_s;
  logic                  blank_s;
  logic                  last_iter_s;

  assign accept_s    = data_vld_i && !busy_q;
  assign data_ext_s  = EXT_W'(data_i);
  assign hex_ovf_s   = |(data_ext_s >> BCD_W);
  assign dec_ovf_s   = (64'(data_i) >= DEC_LIMIT);
  assign bcd_adj_s   = add3(bcd_q);
  assign bcd_step_s  = {bcd_adj_s[BCD_W-2:0], bin_q[DATA_WIDTH-1]};
  assign last_iter_s = (iter_q == ITER_W'(DATA_WIDTH - 1));

  // Load / conversion next state: hex commits immediately, decimal runs
  // DATA_WIDTH double-dabble steps and commits display plus flag together.
  always_comb begin
    busy_d     = busy_q;
    ovf_d      = ovf_q;
    pend_ovf_d = pend_ovf_q;
    dp_d       = dp_q;
    disp_d     = disp_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    if (accept_s) begin
      dp_d = dp_i;
      if (hex_mode_i) begin
        disp_d = data_ext_s[BCD_W-1:0];
        ovf_d  = hex_ovf_s;
      end else begin
        busy_d     = 1'b1;
        bin_d      = data_i;
        bcd_d      = {BCD_W{1'b0}};
        iter_d     = {ITER_W{1'b0}};
        pend_ovf_d = dec_ovf_s;
      end
    end else if (busy_q) begin
      bin_d  = {bin_q[DATA_WIDTH-2:0], 1'b0};
      bcd_d  = bcd_step_s;
      iter_d = iter_q + ITER_W'(1);
      if (last_iter_s) begin
        disp_d = bcd_step_s;
        ovf_d  = pend_ovf_q;
        busy_d = 1'b0;
      end else begin
        disp_d = disp_q;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Scan timing: each digit is held SCAN_DIV clocks, then the index advances.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = {CNT_W{1'b0}};
      if (idx_q == IDX_W'(DIGITS - 1)) begin
        idx_d = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Segment decode for the digit about to be selected, from next-state
  // display data so the pins follow a commit on the same edge.
  always_comb begin
    nib_s   = disp_d[4*int'(idx_d) +: 4];
    blank_s = 1'b0;
    if (lz_blank_i && !ovf_d && (idx_d != IDX_W'(0))) begin
      blank_s = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
        if ((k >= int'(idx_d)) && (disp_d[4*k +: 4] != 4'd0)) begin
          blank_s = 1'b0;
        end else begin
          blank_s = blank_s;
        end
      end
    end else begin
      blank_s = 1'b0;
    end
    if (ovf_d) begin
      seg_d = {dp_d[idx_d], 7'h40};
    end else if (blank_s) begin
      seg_d = {dp_d[idx_d], 7'h00};
    end else begin
      seg_d = {dp_d[idx_d], seg7(nib_s)};
    end
    sel_d = {{(DIGITS-1){1'b0}}, 1'b1} << idx_d;
  end

  // State registers with synchronous reset; reset wins over a load strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      pend_ovf_q <= 1'b0;
      dp_q       <= {DIGITS{1'b0}};
      disp_q     <= {BCD_W{1'b0}};
      bin_q      <= {DATA_WIDTH{1'b0}};
      bcd_q      <= {BCD_W{1'b0}};
      iter_q     <= {ITER_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      idx_q      <= {IDX_W{1'b0}};
      seg_q      <= 8'h3F;
      sel_q      <= {{(DIGITS-1){1'b0}}, 1'b1};
    end else begin
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      pend_ovf_q <= pend_ovf_d;
      dp_q       <= dp_d;
      disp_q     <= disp_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      sel_q      <= sel_d;
    end
  end

  assign busy_o     = busy_q;
  assign overflow_o = ovf_q;
  assign seg_o      = seg_q;
  assign dig_sel_o  = sel_q;

endmodule

// File: tb/tb_segment_led_scan.sv
// Scoreboard bench for segment_led_scan: stimulus pushes the expected
// display (derived arithmetically from the value) and a monitor checks busy
// length, overflow and every scanned digit.
module tb_segment_led_scan;
  localparam int DIGITS = 4;
  localparam int DW     = 16;
  localparam int SD     = 3;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [DW-1:0]     data_i;
  logic              data_vld_i;
  logic              hex_mode_i;
  logic              lz_blank_i;
  logic [DIGITS-1:0] dp_i;
  logic              busy_o;
  logic              overflow_o;
  logic [7:0]        seg_o;
  logic [DIGITS-1:0] dig_sel_o;

  always #5 clk = ~clk;

  segment_led_scan #(.DIGITS(DIGITS), .DATA_WIDTH(DW), .SCAN_DIV(SD)) dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .data_vld_i(data_vld_i),
    .hex_mode_i(hex_mode_i), .lz_blank_i(lz_blank_i), .dp_i(dp_i),
    .busy_o(busy_o), .overflow_o(overflow_o), .seg_o(seg_o), .dig_sel_o(dig_sel_o)
  );

  typedef struct {
    logic [8*DIGITS-1:0] segs;
    logic                ovf;
    int                  busy_len;
    bit                  runs;
  } item_t;

  item_t exp_q[$];
  int checks = 0;
  int failures = 0;
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: digits from division by powers of the base.
  function automatic item_t model(input int unsigned v, input bit hx, input logic [DIGITS-1:0] dp,
                                  input bit lz, input int blen, input bit runs);
    item_t it;
    int unsigned base, lim, pw, d;
    logic [6:0] s;
    base = hx ? 32'd16 : 32'd10;
    lim = 1;
    for (int i = 0; i < DIGITS; i++) lim = lim * base;
    it.ovf = (v >= lim);
    pw = 1;
    for (int k = 0; k < DIGITS; k++) begin
      d = (v / pw) % base;
      if (it.ovf) s = 7'h40;
      else if (lz && k > 0 && v < pw) s = 7'h00;
      else s = seg_tab[d];
      it.segs[8*k +: 8] = {dp[k], s};
      pw = pw * base;
    end
    it.busy_len = blen;
    it.runs = runs;
    return it;
  endfunction

  // Monitor: on a pending expectation, measure busy, then watch a full scan.
  initial begin
    forever begin
      @(posedge clk);
      if (exp_q.size() != 0) begin
        item_t it;
        int n, run, idx;
        bit full;
        logic [DIGITS-1:0] prev, seen;
        it = exp_q[0];
        n = 0;
        @(negedge clk);
        while (busy_o === 1'b1 && n < 100) begin
          n++;
          @(negedge clk);
        end
        chk("busy_len", n, it.busy_len);
        chk("overflow", {31'd0, overflow_o}, {31'd0, it.ovf});
        seen = '0;
        prev = dig_sel_o;
        run = 0;
        full = 1'b0;
        for (int c = 0; c < DIGITS * SD + 2 * SD + 4; c++) begin
          if (c > 0) @(negedge clk);
          checks++;
          if (!$onehot(dig_sel_o)) begin
            failures++;
            $display("FAIL onehot: got %b expected one-hot", dig_sel_o);
          end else begin
            idx = 0;
            for (int b = 0; b < DIGITS; b++) if (dig_sel_o[b]) idx = b;
            seen[idx] = 1'b1;
            chk($sformatf("seg_digit%0d", idx), seg_o, it.segs[8*idx +: 8]);
          end
          if (dig_sel_o != prev) begin
            if (it.runs) begin
              chk("scan_order", dig_sel_o, {prev[DIGITS-2:0], prev[DIGITS-1]});
              if (full) chk("slot_len", run, SD);
            end
            full = 1'b1;
            run = 1;
            prev = dig_sel_o;
          end else begin
            run++;
          end
        end
        chk("digits_seen", seen, {DIGITS{1'b1}});
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic issue(input int unsigned v, input bit hx, input logic [DIGITS-1:0] dp,
                       input bit lz, input bit push);
    @(negedge clk);
    lz_blank_i = lz;
    data_i = v[DW-1:0];
    hex_mode_i = hx;
    dp_i = dp;
    data_vld_i = 1'b1;
    if (push) exp_q.push_back(model(v, hx, dp, lz, hx ? 0 : DW, 1'b1));
    @(negedge clk);
    data_vld_i = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int unsigned v;
    bit hx, lz;
    rst_i = 1'b1;
    data_i = '0;
    data_vld_i = 1'b0;
    hex_mode_i = 1'b0;
    lz_blank_i = 1'b0;
    dp_i = '0;
    exp_q.push_back(model(0, 1'b1, '0, 1'b0, 0, 1'b0));
    repeat (3) @(negedge clk);
    chk("rst_seg", seg_o, 8'h3F);
    chk("rst_sel", dig_sel_o, 4'b0001);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_ovf", overflow_o, 1'b0);
    rst_i = 1'b0;
    wait_done();

    issue(0, 1'b1, 4'b0000, 1'b1, 1'b1);       wait_done();
    issue(1234, 1'b0, 4'b0000, 1'b0, 1'b1);    wait_done();
    issue(16'hBEEF, 1'b1, 4'b0100, 1'b0, 1'b1); wait_done();
    issue(10000, 1'b0, 4'b0000, 1'b0, 1'b1);   wait_done();
    issue(42, 1'b0, 4'b0000, 1'b1, 1'b1);      wait_done();

    // Load strobe during conversion must be ignored.
    issue(1234, 1'b0, 4'b0000, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    data_i = 16'd99;
    hex_mode_i = 1'b1;
    data_vld_i = 1'b1;
    @(negedge clk);
    data_vld_i = 1'b0;
    wait_done();

    // Reset in the middle of a conversion discards it.
    issue(1234, 1'b0, 4'b1010, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("busy_before_rst", busy_o, 1'b1);
    rst_i = 1'b1;
    exp_q.push_back(model(0, 1'b1, '0, 1'b1, 0, 1'b0));
    @(negedge clk);
    rst_i = 1'b0;
    wait_done();

    for (int i = 0; i < 24; i++) begin
      hx = ($urandom % 2) == 1;
      lz = ($urandom % 2) == 1;
      if (!hx && ($urandom % 2) == 1) v = $urandom_range(0, 11000);
      else if (($urandom % 3) == 0) v = $urandom_range(0, 300);
      else v = $urandom_range(0, 65535);
      issue(v, hx, 4'($urandom), lz, 1'b1);
      wait_done();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/segment_led_scan.md
Name: segment_led_scan

Overview:
Time-multiplexed driver for a DIGITS-wide common-cathode seven-segment display. Converts a DATA_WIDTH-bit unsigned value to decimal with a sequential double-dabble engine, or shows it directly in hex. Scans one digit at a time at a programmable rate. Sits between the LED-count/status logic and the board display pins, and replaces fixed two-digit static decoding.

Parameters:
DIGITS, 4, number of display digits (2..8)
DATA_WIDTH, 16, width of input value (>= 4, <= 32)
SCAN_DIV, 1000, clock cycles each digit stays selected (>= 2)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
data_i  in  DATA_WIDTH  unsigned value to display
data_vld_i  in  1  load strobe for data_i, hex_mode_i, dp_i
hex_mode_i  in  1  1 = hex digits, 0 = decimal
lz_blank_i  in  1  1 = blank leading zeros (static level, sampled every cycle)
dp_i  in  DIGITS  decimal-point enable per digit, bit 0 = rightmost
busy_o  out  1  decimal conversion in progress
overflow_o  out  1  latched value not representable in DIGITS digits
seg_o  out  8  segments {dp,g,f,e,d,c,b,a}, active-high
dig_sel_o  out  DIGITS  one-hot digit enable, active-high

Behaviour:
- Reset (rst_i high at an edge): seg_o=8'h3F, dig_sel_o=1, busy_o=0, overflow_o=0, display nibbles=0, dp register=0, scan counter=0, digit index=0. Reset mid-conversion aborts it and discards the result.
- Acceptance: data_vld_i && !busy_o at edge T latches data_i, hex_mode_i and dp_i. data_vld_i while busy_o=1 is ignored. No queueing.
- Hex mode: nibble k = data[4k+3:4k]. Display register and overflow_o are updated at edge T and visible in cycle T+1. busy_o stays 0. overflow_o=1 if any data bit at or above 4*DIGITS is set.
- Decimal mode: overflow is determined at acceptance as value >= 10**DIGITS. busy_o=1 for cycles T+1..T+DATA_WIDTH, with one shift-and-add-3 iteration per cycle (add 3 to each BCD nibble >= 5, then shift left by 1). The display register and overflow_o update atomically at the edge ending cycle T+DATA_WIDTH and are visible at T+DATA_WIDTH+1 with busy_o=0. The old display is held throughout conversion, so there is no partial-result flicker.
- Overflow display: every digit shows 8'h40 ("-"). dp is still applied and leading-zero blanking is disabled.
- Segment table (a..g): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Leading-zero blanking: when lz_blank_i=1, digit k>0 is blanked (seg[6:0]=0) if it and all higher digits are 0. Digit 0 is never blanked. dp of a blanked digit is still driven from the dp register.
- Scan: the counter runs 0..SCAN_DIV-1. At terminal count it wraps to 0 and the digit index advances, wrapping from DIGITS-1 to 0.
- Output timing: seg_o and dig_sel_o are registered. They change at the same edge as the index and always describe the same digit, with no cycle of mismatch. dig_sel_o is exactly one-hot at all times after reset. seg_o reflects display-register changes within 1 cycle, even mid-slot.
- Simultaneous reset and data_vld_i: reset wins.
- Arithmetic: the BCD register is 4*DIGITS bits. Bits shifted out past the top digit are discarded, since only the overflow flag matters for them.

Test Plan:
- Reset: hold rst_i for 3 cycles -> seg_o=8'h3F, dig_sel_o=4'b0001, busy_o=0, overflow_o=0. Over 4*SCAN_DIV cycles, digits 1..3 show 8'h3F when lz_blank_i=0 and 8'h00 when lz_blank_i=1.
- Decimal 1234: data_i=1234, hex=0 -> busy_o high exactly 16 cycles. Then digits 3..0 show 06,5B,4F,66.
- Hex 0xBEEF with dp_i=4'b0100 -> visible next cycle, no busy. Digits show 7C,79,79,71, and digit 2 seg_o=8'hF9.
- Decimal 10000 with DIGITS=4 -> overflow_o=1 and all digits 8'h40. Then load 42 -> overflow_o=0; with lz_blank_i=1, digits show 00,00,66,5B.
- data_vld_i pulsed with 99 during a 1234 conversion -> ignored; the result stays 1234. Asserting rst_i at cycle 5 of a conversion -> busy_o=0 and display reset to 0.
- Scan: with SCAN_DIV=3 and DIGITS=4 -> dig_sel_o sequence 0001,0010,0100,1000,0001, each held exactly 3 cycles, always one-hot.
